// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control unit and its datapath.
// The master side drives the datapath strobes, selects and debug state.
interface multicycle_control_if #(
   parameter int ALUOP_W = 2
);
   logic [5:0]         opcode;
   logic [5:0]         Funct;
   logic               PCWrite;
   logic               PCWriteCond;
   logic               IorD;
   logic               MemRead;
   logic               MemWrite;
   logic               IRWrite;
   logic               MemtoReg;
   logic               ALUSrcA;
   logic               RegWrite;
   logic               RegDst;
   logic               BranchNe;
   logic [1:0]         ALUSrcB;
   logic [1:0]         PCSource;
   logic [ALUOP_W-1:0] ALUOp;
   logic               illegal_op;
   logic [3:0]         state;

   modport master (
      input  opcode, Funct,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
      output MemtoReg, ALUSrcA, RegWrite, RegDst, BranchNe,
      output ALUSrcB, PCSource, ALUOp, illegal_op, state
   );

   modport slave (
      output opcode, Funct,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
      input  MemtoReg, ALUSrcA, RegWrite, RegDst, BranchNe,
      input  ALUSrcB, PCSource, ALUOp, illegal_op, state
   );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath,
// with BNE, illegal-opcode detection and memory wait states.
module multicycle_control #(
   parameter int ALUOP_W    = 2,
   parameter int MEM_WAIT   = 0,
   parameter int ENABLE_BNE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.master bus
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11
   } state_t;

   localparam logic [3:0] WAIT_N = 4'(MEM_WAIT);
   localparam bit         BNE_ON = (ENABLE_BNE != 0);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t     st, nxt;
   logic [3:0] wait_cnt, cnt_nxt;
   logic       last;

   logic       pcw, pcwc, iord, mrd, mwr, irw;
   logic       m2r, srca, rw, rdst, bne, ill;
   logic [1:0] srcb, pcsrc, aop;

   // Funct is decoded by the ALU control, not here
   logic       funct_unused;
   assign funct_unused = ^bus.Funct;

   assign last = (wait_cnt == WAIT_N);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= FETCH;
         wait_cnt <= '0;
      end else begin
         st       <= nxt;
         wait_cnt <= cnt_nxt;
      end
   end

   always_comb begin
      nxt     = FETCH;
      cnt_nxt = '0;
      pcw     = 1'b0;
      pcwc    = 1'b0;
      iord    = 1'b0;
      mrd     = 1'b0;
      mwr     = 1'b0;
      irw     = 1'b0;
      m2r     = 1'b0;
      srca    = 1'b0;
      rw      = 1'b0;
      rdst    = 1'b0;
      bne     = 1'b0;
      ill     = 1'b0;
      srcb    = 2'b00;
      pcsrc   = 2'b00;
      aop     = 2'b00;
      unique case (st)
         FETCH: begin
            mrd  = 1'b1;
            srcb = 2'b01;
            if (last) begin
               irw = 1'b1;
               pcw = 1'b1;
               nxt = DECODE;
            end else begin
               nxt     = FETCH;
               cnt_nxt = 4'(wait_cnt + 4'd1);
            end
         end
         DECODE: begin
            srcb = 2'b11;
            unique case (1'b1)
               (bus.opcode == OP_R):                  nxt = EXECUTE;
               (bus.opcode == OP_LW),
               (bus.opcode == OP_SW):                 nxt = MEMADR;
               (bus.opcode == OP_BEQ):                nxt = BRANCH;
               (bus.opcode == OP_BNE) && BNE_ON:      nxt = BRANCH;
               (bus.opcode == OP_ADDI):               nxt = ADDIEXEC;
               (bus.opcode == OP_J):                  nxt = JUMP;
               default: begin
                  ill = 1'b1;
                  nxt = FETCH;
               end
            endcase
         end
         MEMADR: begin
            srca = 1'b1;
            srcb = 2'b10;
            nxt  = (bus.opcode == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            mrd  = 1'b1;
            iord = 1'b1;
            if (last) begin
               nxt = MEMWB;
            end else begin
               nxt     = MEMREAD;
               cnt_nxt = 4'(wait_cnt + 4'd1);
            end
         end
         MEMWB: begin
            rw  = 1'b1;
            m2r = 1'b1;
         end
         MEMWRITE: begin
            mwr  = 1'b1;
            iord = 1'b1;
            if (!last) begin
               nxt     = MEMWRITE;
               cnt_nxt = 4'(wait_cnt + 4'd1);
            end
         end
         EXECUTE: begin
            srca = 1'b1;
            aop  = 2'b10;
            nxt  = ALUWB;
         end
         ALUWB: begin
            rw   = 1'b1;
            rdst = 1'b1;
         end
         BRANCH: begin
            srca  = 1'b1;
            aop   = 2'b01;
            pcwc  = 1'b1;
            pcsrc = 2'b01;
            bne   = (bus.opcode == OP_BNE);
         end
         ADDIEXEC: begin
            srca = 1'b1;
            srcb = 2'b10;
            nxt  = ADDIWB;
         end
         ADDIWB: begin
            rw = 1'b1;
         end
         JUMP: begin
            pcw   = 1'b1;
            pcsrc = 2'b10;
         end
         default: begin
            nxt = FETCH;
         end
      endcase
   end

   // reset masks every output at once, so an abort never leaks a write
   assign bus.PCWrite     = pcw  & ~rst;
   assign bus.PCWriteCond = pcwc & ~rst;
   assign bus.IorD        = iord & ~rst;
   assign bus.MemRead     = mrd  & ~rst;
   assign bus.MemWrite    = mwr  & ~rst;
   assign bus.IRWrite     = irw  & ~rst;
   assign bus.MemtoReg    = m2r  & ~rst;
   assign bus.ALUSrcA     = srca & ~rst;
   assign bus.RegWrite    = rw   & ~rst;
   assign bus.RegDst      = rdst & ~rst;
   assign bus.BranchNe    = bne  & ~rst;
   assign bus.illegal_op  = ill  & ~rst;
   assign bus.ALUSrcB     = rst ? 2'b00 : srcb;
   assign bus.PCSource    = rst ? 2'b00 : pcsrc;
   assign bus.ALUOp       = rst ? '0 : ALUOP_W'(aop);
   assign bus.state       = rst ? 4'd0 : st;
endmodule

// File: tb/tb_multicycle_control.sv
// Checks three control-unit builds (wait states, BNE on/off, ALUOp width)
// against an instruction-level model of the expected cycle sequence.
module tb_multicycle_control;
   typedef struct packed {
      logic       pcw, pcwc, iord, mrd, mwr, irw;
      logic       m2r, srca, rw, rdst, bne;
      logic [1:0] srcb, pcsrc;
      logic [3:0] aop;
      logic       ill;
      logic [3:0] st;
   } ctl_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode, funct;
   int         sel;
   int         ncmp = 0;
   int         nfail = 0;
   ctl_t       q[$];
   ctl_t       obs, oa, ob, oc;
   int         wtab[3] = '{2, 3, 0};
   bit         btab[3] = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   multicycle_control_if #(.ALUOP_W(4)) ia ();
   multicycle_control_if #(.ALUOP_W(2)) ib ();
   multicycle_control_if #(.ALUOP_W(3)) ic ();

   assign ia.opcode = opcode;
   assign ia.Funct  = funct;
   assign ib.opcode = opcode;
   assign ib.Funct  = funct;
   assign ic.opcode = opcode;
   assign ic.Funct  = funct;

   multicycle_control #(.ALUOP_W(4), .MEM_WAIT(2), .ENABLE_BNE(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ia));
   multicycle_control #(.ALUOP_W(2), .MEM_WAIT(3), .ENABLE_BNE(0)) dut_b (
      .clk(clk), .rst(rst), .bus(ib));
   multicycle_control #(.ALUOP_W(3), .MEM_WAIT(0), .ENABLE_BNE(1)) dut_c (
      .clk(clk), .rst(rst), .bus(ic));

   assign oa = {ia.PCWrite, ia.PCWriteCond, ia.IorD, ia.MemRead,
                ia.MemWrite, ia.IRWrite, ia.MemtoReg, ia.ALUSrcA,
                ia.RegWrite, ia.RegDst, ia.BranchNe, ia.ALUSrcB,
                ia.PCSource, ia.ALUOp, ia.illegal_op, ia.state};
   assign ob = {ib.PCWrite, ib.PCWriteCond, ib.IorD, ib.MemRead,
                ib.MemWrite, ib.IRWrite, ib.MemtoReg, ib.ALUSrcA,
                ib.RegWrite, ib.RegDst, ib.BranchNe, ib.ALUSrcB,
                ib.PCSource, 2'b00, ib.ALUOp, ib.illegal_op, ib.state};
   assign oc = {ic.PCWrite, ic.PCWriteCond, ic.IorD, ic.MemRead,
                ic.MemWrite, ic.IRWrite, ic.MemtoReg, ic.ALUSrcA,
                ic.RegWrite, ic.RegDst, ic.BranchNe, ic.ALUSrcB,
                ic.PCSource, 1'b0, ic.ALUOp, ic.illegal_op, ic.state};

   always_comb begin
      obs = '0;
      case (sel)
         0: obs = oa;
         1: obs = ob;
         default: obs = oc;
      endcase
   end

   task automatic chk(input string tag, input ctl_t got, input ctl_t exp);
      ncmp++;
      assert (got === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic ctl_t mk(input int s);
      ctl_t c;
      c = '0;
      c.st = 4'(s);
      return c;
   endfunction

   // expected per-cycle outputs for one whole instruction
   task automatic build(input logic [5:0] op, input int w, input bit bon);
      ctl_t c;
      bit   legal;
      q.delete();
      for (int i = 0; i <= w; i++) begin
         c = mk(0);
         c.mrd = 1; c.srcb = 2'b01;
         if (i == w) begin c.irw = 1; c.pcw = 1; end
         q.push_back(c);
      end
      legal = (op == 6'd0) || (op == 6'd35) || (op == 6'd43) ||
              (op == 6'd4) || (op == 6'd8) || (op == 6'd2) ||
              ((op == 6'd5) && bon);
      c = mk(1);
      c.srcb = 2'b11;
      c.ill  = !legal;
      q.push_back(c);
      if (!legal) return;
      case (op)
         6'd0: begin
            c = mk(6); c.srca = 1; c.aop = 4'd2; q.push_back(c);
            c = mk(7); c.rw = 1; c.rdst = 1; q.push_back(c);
         end
         6'd35, 6'd43: begin
            c = mk(2); c.srca = 1; c.srcb = 2'b10; q.push_back(c);
            for (int i = 0; i <= w; i++) begin
               c = mk(op == 6'd35 ? 3 : 5);
               c.iord = 1;
               if (op == 6'd35) c.mrd = 1; else c.mwr = 1;
               q.push_back(c);
            end
            if (op == 6'd35) begin
               c = mk(4); c.rw = 1; c.m2r = 1; q.push_back(c);
            end
         end
         6'd4, 6'd5: begin
            c = mk(8); c.srca = 1; c.aop = 4'd1; c.pcwc = 1;
            c.pcsrc = 2'b01; c.bne = (op == 6'd5); q.push_back(c);
         end
         6'd8: begin
            c = mk(9); c.srca = 1; c.srcb = 2'b10; q.push_back(c);
            c = mk(10); c.rw = 1; q.push_back(c);
         end
         default: begin
            c = mk(11); c.pcw = 1; c.pcsrc = 2'b10; q.push_back(c);
         end
      endcase
   endtask

   task automatic run_instr(input logic [5:0] op, input int abort_at);
      opcode = op;
      funct  = 6'($urandom);
      build(op, wtab[sel], btab[sel]);
      for (int i = 0; i < q.size(); i++) begin
         #1;
         chk($sformatf("s%0d op%02h c%0d", sel, op, i), obs, q[i]);
         if (i == abort_at) begin
            rst = 1'b1;
            #1;
            chk($sformatf("s%0d abort", sel), obs, '0);
            @(negedge clk);
            #1;
            chk($sformatf("s%0d abort_hold", sel), obs, '0);
            rst = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   logic [5:0] optab[7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd2};

   initial begin
      rst    = 1'b1;
      opcode = 6'd0;
      funct  = 6'd0;
      sel    = 0;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1 chk($sformatf("rst_idle s%0d", s), obs, '0);
      end
      opcode = 6'd35;
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1 chk($sformatf("rst_lw s%0d", s), obs, '0);
      end
      for (int p = 0; p < 3; p++) begin
         sel = p;
         rst = 1'b1;
         @(negedge clk);
         #1 chk($sformatf("rst_phase s%0d", p), obs, '0);
         rst = 1'b0;
         case (p)
            0: begin
               run_instr(6'd0, -1);
               run_instr(6'd35, -1);
               run_instr(6'd2, -1);
               run_instr(6'd5, -1);
               run_instr(6'd4, -1);
               run_instr(6'd63, -1);
            end
            1: begin
               run_instr(6'd5, -1);
               run_instr(6'd43, 7);
               run_instr(6'd0, -1);
               run_instr(6'd43, -1);
            end
            default: begin
               run_instr(6'd0, -1);
               run_instr(6'd63, -1);
               run_instr(6'd8, -1);
               run_instr(6'd35, -1);
            end
         endcase
         for (int n = 0; n < 30; n++) begin
            int k;
            k = $urandom_range(0, 8);
            if (k < 7) run_instr(optab[k], -1);
            else run_instr(6'($urandom_range(0, 63)), -1);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
